serial_twos_decoder: RTL and testbench



---
 rtl/serial_twos_decoder.sv | 82 ++++++++
 tb/tb_serial_twos_decoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_twos_decoder.sv
// serial_twos_decoder: LSB-first serial two's-complement word to parallel sign/magnitude
module serial_twos_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             frame_start,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_raw,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_sign,
   output logic             out_minneg,
   output logic             drop_err
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic {IDLE, RECV} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] raw, raw_n, neg, neg_n;
   logic seen, seen_n, done, done_n, drop_n;
   assign busy = state == RECV;
   // neg keeps bits until the first 1 has passed, then inverts: the serial negation
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      raw_n = raw;
      neg_n = neg;
      seen_n = seen;
      done_n = 1'b0;
      drop_n = bit_valid && !frame_start && state == IDLE;
      if (bit_valid && frame_start) begin
         state_n = RECV;
         cnt_n = CW'(1);
         seen_n = bit_in;
         raw_n[0] = bit_in;
         neg_n[0] = bit_in;
      end else if (bit_valid && state == RECV) begin
         raw_n[cnt] = bit_in;
         neg_n[cnt] = seen ^ bit_in;
         seen_n = seen | bit_in;
         cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
         state_n = (cnt == LAST) ? IDLE : RECV;
         done_n = cnt == LAST;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         raw <= '0;
         neg <= '0;
         seen <= 1'b0;
         done <= 1'b0;
         drop_err <= 1'b0;
         out_valid <= 1'b0;
         out_raw <= '0;
         out_mag <= '0;
         out_sign <= 1'b0;
         out_minneg <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         raw <= raw_n;
         neg <= neg_n;
         seen <= seen_n;
         done <= done_n;
         drop_err <= drop_n;
         out_valid <= done;
         if (done) begin
            out_raw <= raw;
            out_sign <= raw[WIDTH-1];
            out_mag <= raw[WIDTH-1] ? neg : raw;
            out_minneg <= raw == MIN_NEG;
         end
      end
   end
endmodule

// File: tb/tb_serial_twos_decoder.sv
// tb_serial_twos_decoder: directed frames with a queued scoreboard checked by a monitor
module tb_serial_twos_decoder;
   logic clk = 1'b0, reset = 1'b1, bit_valid = 1'b0, bit_in = 1'b0, frame_start = 1'b0;
   logic busy, out_valid, out_sign, out_minneg, drop_err;
   logic [7:0] out_raw, out_mag;
   int cyc = 0, passed = 0, total = 0;
   typedef struct {
      logic [7:0] raw;
      logic [7:0] mag;
      logic sign;
      logic minneg;
      int at;
   } exp_t;
   exp_t sb[$];

   serial_twos_decoder #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
      .frame_start(frame_start), .busy(busy), .out_valid(out_valid),
      .out_raw(out_raw), .out_mag(out_mag), .out_sign(out_sign),
      .out_minneg(out_minneg), .drop_err(drop_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(negedge clk) if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
         exp_t e;
         e = sb.pop_front();
         chk("out_raw", out_raw, e.raw);
         chk("out_mag", out_mag, e.mag);
         chk("out_sign", out_sign, e.sign);
         chk("out_minneg", out_minneg, e.minneg);
         chk("latency_cycle", cyc, e.at);
      end
   end

   task automatic send_bits(input logic [7:0] w, input int n, input int stall_after,
                            input int stalls, input logic push, input logic [7:0] mag,
                            input logic sign, input logic minneg);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bit_valid = 1'b1;
         frame_start = i == 0;
         bit_in = w[i];
         if (i == 0 && push) sb.push_back('{w, mag, sign, minneg, cyc + 9 + stalls});
         if (i == stall_after) begin
            for (int s = 0; s < stalls; s++) begin
               @(negedge clk);
               bit_valid = 1'b0;
               chk("busy_in_stall", busy, 1);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bit_valid = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_raw", out_raw, 0);
      chk("reset_out_mag", out_mag, 0);
      chk("reset_drop_err", drop_err, 0);
      reset = 1'b0;
      send_bits(8'h05, 8, -1, 0, 1'b1, 8'h05, 1'b0, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      frame_start = 1'b0;
      chk("busy_low_after_last", busy, 0);
      idle(4);
      send_bits(8'hFB, 8, -1, 0, 1'b1, 8'h05, 1'b1, 1'b0);
      send_bits(8'hC0, 8, -1, 0, 1'b1, 8'h40, 1'b1, 1'b0);
      idle(4);
      send_bits(8'h80, 8, -1, 0, 1'b1, 8'h80, 1'b1, 1'b1);
      send_bits(8'h00, 8, -1, 0, 1'b1, 8'h00, 1'b0, 1'b0);
      idle(4);
      send_bits(8'hFB, 8, 3, 3, 1'b1, 8'h05, 1'b1, 1'b0);
      idle(4);
      send_bits(8'hFF, 4, -1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_bits(8'h7F, 8, -1, 0, 1'b1, 8'h7F, 1'b0, 1'b0);
      idle(12);
      send_bits(8'hAA, 6, -1, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      frame_start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_busy", busy, 0);
      chk("midreset_out_raw", out_raw, 0);
      chk("midreset_out_mag", out_mag, 0);
      chk("midreset_out_sign", out_sign, 0);
      chk("midreset_out_minneg", out_minneg, 0);
      idle(12);
      @(negedge clk);
      bit_valid = 1'b1;
      frame_start = 1'b0;
      bit_in = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      chk("drop_err_pulse", drop_err, 1);
      chk("drop_busy_idle", busy, 0);
      @(negedge clk);
      chk("drop_err_cleared", drop_err, 0);
      chk("drop_no_frame", busy, 0);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
